fetch_stage: RTL and testbench

- Front-end instruction fetch stage. Sits directly upstream of icache_prefetch: owns the PC and issues one-word read requests on its ufp port.
- Captures each returned instruction into a {pc, inst, pc_next} packet and pushes it into the instruction queue.
- Handles backend redirects (mispredict/flush). Discards any in-flight response, because a request cannot be cancelled once issued.

---
 rtl/fetch_stage_pkg.sv | 20 ++
 rtl/fetch_stage.sv | 92 +++++++++
 tb/tb_fetch_stage.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared types for the front-end fetch stage.
package fetch_stage_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h1eceb000;

  // Packet pushed into the instruction queue; pc occupies the MSBs.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc_next;
  } fetch_pkt_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DISCARD
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues one-word reads, and pushes
// {pc, inst, pc_next} packets into the instruction queue.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] imem_addr,
  output logic [3:0]      imem_rmask,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            imem_resp,
  input  logic            iq_full,
  output logic            iq_push,
  output fetch_pkt_t      iq_pkt
);

  fetch_state_t    r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_req_pc;
  logic            r_hold_valid;
  fetch_pkt_t      r_hold_pkt;

  fetch_state_t    w_state_next;
  fetch_pkt_t      w_resp_pkt;
  logic            w_resp_wanted;
  logic            w_can_issue;
  logic            w_drain;
  logic            w_push_resp;
  logic            w_capture;

  // Issue/push decisions; request and push are combinational so a hitting
  // downstream sustains one instruction per cycle.
  always_comb begin
    w_resp_pkt    = '{pc: r_req_pc, inst: imem_rdata, pc_next: r_req_pc + 32'd4};
    w_resp_wanted = (r_state == WAIT) && imem_resp;
    w_can_issue   = !rst && !redirect && !iq_full && !r_hold_valid &&
                    ((r_state == IDLE) || imem_resp);
    w_drain       = !rst && !redirect && r_hold_valid && !iq_full;
    w_push_resp   = !rst && !redirect && w_resp_wanted && !iq_full;
    w_capture     = !rst && !redirect && w_resp_wanted && iq_full;

    imem_addr  = r_pc;
    imem_rmask = w_can_issue ? 4'hF : 4'h0;
    iq_push    = w_drain || w_push_resp;
    iq_pkt     = r_hold_valid ? r_hold_pkt : w_resp_pkt;
  end

  // Next state: redirect wins; an outstanding request without a response
  // must still be drained, so it moves to DISCARD.
  always_comb begin
    w_state_next = r_state;
    if (redirect) begin
      w_state_next = ((r_state != IDLE) && !imem_resp) ? DISCARD : IDLE;
    end else if (w_can_issue) begin
      w_state_next = WAIT;
    end else if ((r_state != IDLE) && imem_resp) begin
      w_state_next = IDLE;
    end
  end

  // State, PC, outstanding-request address and single-entry hold buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_pc         <= RESET_PC;
      r_req_pc     <= RESET_PC;
      r_hold_valid <= 1'b0;
      r_hold_pkt   <= '0;
    end else begin
      r_state <= w_state_next;
      if (redirect) begin
        r_pc <= redirect_pc;
      end else if (w_can_issue) begin
        r_pc <= r_pc + 32'd4;
      end
      if (w_can_issue) begin
        r_req_pc <= r_pc;
      end
      if (redirect || w_drain) begin
        r_hold_valid <= 1'b0;
      end else if (w_capture) begin
        r_hold_valid <= 1'b1;
        r_hold_pkt   <= w_resp_pkt;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage with a latency-configurable memory model.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam logic [31:0] B = 32'h1eceb000;
  localparam logic [31:0] K = 32'hAAAA5555;

  typedef struct packed {
    logic        redir;
    logic [31:0] rpc;
    logic        full;
    logic [3:0]  lat;
    logic        spur;
    logic        push;
    logic [31:0] ppc;
    logic        req;
    logic [31:0] addr;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        iq_full;
  logic        iq_push;
  fetch_pkt_t  iq_pkt;

  int n_tests = 0;
  int n_fail  = 0;

  logic        pend_v;
  logic [31:0] pend_addr;
  logic [3:0]  pend_cnt;
  logic        s_push;
  logic [3:0]  s_rmask;
  logic [31:0] s_addr;
  fetch_pkt_t  s_pkt;

  fetch_stage dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_rmask(imem_rmask), .imem_rdata(imem_rdata),
    .imem_resp(imem_resp), .iq_full(iq_full), .iq_push(iq_push), .iq_pkt(iq_pkt)
  );

  always #5 clk = ~clk;

  function automatic vec_t cyc(input logic redir, input logic [31:0] rpc, input logic full,
                               input logic [3:0] lat, input logic spur, input logic push,
                               input logic [31:0] ppc, input logic req, input logic [31:0] addr);
    cyc = '{redir, rpc, full, lat, spur, push, ppc, req, addr};
  endfunction

  // One cycle: drive inputs, let the model answer, sample outputs mid-cycle.
  task automatic tick(input vec_t v);
    redirect    = v.redir;
    redirect_pc = v.rpc;
    iq_full     = v.full;
    imem_resp   = (pend_v && (pend_cnt == 4'd0)) || v.spur;
    imem_rdata  = (pend_v && (pend_cnt == 4'd0)) ? (pend_addr ^ K) :
                  (v.spur ? 32'hdeadbeef : 32'h0);
    #1;
    s_push  = iq_push;
    s_rmask = imem_rmask;
    s_addr  = imem_addr;
    s_pkt   = iq_pkt;
    if (pend_v) begin
      if (pend_cnt == 4'd0) pend_v = 1'b0;
      else pend_cnt = pend_cnt - 4'd1;
    end
    if (s_rmask == 4'hF) begin
      pend_v    = 1'b1;
      pend_addr = s_addr;
      pend_cnt  = v.lat - 4'd1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; iq_full = 1'b0;
    imem_resp = 1'b0; imem_rdata = '0; pend_v = 1'b0; pend_cnt = '0; pend_addr = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect = 1'b0; iq_full = 1'b0; imem_resp = 1'b0; pend_v = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_tests++;
    if ({imem_rmask, iq_push} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: rmask=%h push=%b, required rmask=0 push=0", imem_rmask, iq_push);
    end
    rst = 1'b0; iq_full = 1'b1;
    #1;
    n_tests++;
    if ({imem_rmask, iq_push, imem_addr} !== {4'h0, 1'b0, B}) begin
      n_fail++;
      $display("FAIL reset_pc: rmask=%h push=%b addr=%h, required 0/0/%h", imem_rmask, iq_push, imem_addr, B);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stream();
    vec_t v[$];
    logic [132:0] got, exp;
    do_reset();
    v.push_back(cyc(0, 0, 0, 1, 0, 0, 0, 1, B));
    for (int k = 1; k <= 4; k++)
      v.push_back(cyc(0, 0, 0, 1, 0, 1, B + 32'(4 * (k - 1)), 1, B + 32'(4 * k)));
    foreach (v[i]) begin
      tick(v[i]);
      got = {s_push, s_rmask, v[i].push ? s_pkt : 96'h0, v[i].req ? s_addr : 32'h0};
      exp = {v[i].push, v[i].req ? 4'hF : 4'h0,
             v[i].push ? {v[i].ppc, v[i].ppc ^ K, v[i].ppc + 32'd4} : 96'h0,
             v[i].req ? v[i].addr : 32'h0};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL stream[%0d]: got=%h required=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_full_hold();
    vec_t v[$];
    logic [132:0] got, exp;
    do_reset();
    v.push_back(cyc(0, 0, 0, 1, 0, 0, 0, 1, B));
    v.push_back(cyc(0, 0, 0, 1, 0, 1, B, 1, B + 32'h4));
    for (int k = 0; k < 3; k++) v.push_back(cyc(0, 0, 1, 1, 0, 0, 0, 0, 0));
    v.push_back(cyc(0, 0, 0, 1, 0, 1, B + 32'h4, 0, 0));
    v.push_back(cyc(0, 0, 0, 1, 0, 0, 0, 1, B + 32'h8));
    v.push_back(cyc(0, 0, 0, 1, 0, 1, B + 32'h8, 1, B + 32'hc));
    foreach (v[i]) begin
      tick(v[i]);
      got = {s_push, s_rmask, v[i].push ? s_pkt : 96'h0, v[i].req ? s_addr : 32'h0};
      exp = {v[i].push, v[i].req ? 4'hF : 4'h0,
             v[i].push ? {v[i].ppc, v[i].ppc ^ K, v[i].ppc + 32'd4} : 96'h0,
             v[i].req ? v[i].addr : 32'h0};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL full_hold[%0d]: got=%h required=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_redirect_inflight();
    vec_t v[$];
    logic [132:0] got, exp;
    do_reset();
    v.push_back(cyc(0, 0, 0, 1, 0, 0, 0, 1, B));
    for (int k = 1; k <= 3; k++)
      v.push_back(cyc(0, 0, 0, 1, 0, 1, B + 32'(4 * (k - 1)), 1, B + 32'(4 * k)));
    v.push_back(cyc(0, 0, 0, 5, 0, 1, B + 32'hc, 1, B + 32'h10));
    v.push_back(cyc(1, B + 32'h100, 0, 1, 0, 0, 0, 0, 0));
    for (int k = 0; k < 3; k++) v.push_back(cyc(0, 0, 0, 1, 0, 0, 0, 0, 0));
    v.push_back(cyc(0, 0, 0, 1, 0, 0, 0, 1, B + 32'h100));
    v.push_back(cyc(0, 0, 0, 1, 0, 1, B + 32'h100, 1, B + 32'h104));
    foreach (v[i]) begin
      tick(v[i]);
      got = {s_push, s_rmask, v[i].push ? s_pkt : 96'h0, v[i].req ? s_addr : 32'h0};
      exp = {v[i].push, v[i].req ? 4'hF : 4'h0,
             v[i].push ? {v[i].ppc, v[i].ppc ^ K, v[i].ppc + 32'd4} : 96'h0,
             v[i].req ? v[i].addr : 32'h0};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL redirect_inflight[%0d]: got=%h required=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_redirect_with_resp();
    vec_t v[$];
    logic [132:0] got, exp;
    do_reset();
    v.push_back(cyc(0, 0, 0, 1, 0, 0, 0, 1, B));
    v.push_back(cyc(1, B + 32'h400, 0, 1, 0, 0, 0, 0, 0));
    v.push_back(cyc(0, 0, 0, 1, 0, 0, 0, 1, B + 32'h400));
    v.push_back(cyc(0, 0, 0, 1, 0, 1, B + 32'h400, 1, B + 32'h404));
    foreach (v[i]) begin
      tick(v[i]);
      got = {s_push, s_rmask, v[i].push ? s_pkt : 96'h0, v[i].req ? s_addr : 32'h0};
      exp = {v[i].push, v[i].req ? 4'hF : 4'h0,
             v[i].push ? {v[i].ppc, v[i].ppc ^ K, v[i].ppc + 32'd4} : 96'h0,
             v[i].req ? v[i].addr : 32'h0};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL redirect_with_resp[%0d]: got=%h required=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_double_redirect();
    vec_t v[$];
    logic [132:0] got, exp;
    do_reset();
    v.push_back(cyc(0, 0, 0, 3, 0, 0, 0, 1, B));
    v.push_back(cyc(1, B + 32'h200, 0, 1, 0, 0, 0, 0, 0));
    v.push_back(cyc(1, B + 32'h300, 0, 1, 0, 0, 0, 0, 0));
    v.push_back(cyc(0, 0, 0, 1, 0, 0, 0, 1, B + 32'h300));
    v.push_back(cyc(0, 0, 0, 1, 0, 1, B + 32'h300, 1, B + 32'h304));
    foreach (v[i]) begin
      tick(v[i]);
      got = {s_push, s_rmask, v[i].push ? s_pkt : 96'h0, v[i].req ? s_addr : 32'h0};
      exp = {v[i].push, v[i].req ? 4'hF : 4'h0,
             v[i].push ? {v[i].ppc, v[i].ppc ^ K, v[i].ppc + 32'd4} : 96'h0,
             v[i].req ? v[i].addr : 32'h0};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL double_redirect[%0d]: got=%h required=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_wrap();
    vec_t v[$];
    logic [132:0] got, exp;
    do_reset();
    v.push_back(cyc(1, 32'hFFFFFFFC, 0, 1, 0, 0, 0, 0, 0));
    v.push_back(cyc(0, 0, 0, 1, 0, 0, 0, 1, 32'hFFFFFFFC));
    v.push_back(cyc(0, 0, 0, 1, 0, 1, 32'hFFFFFFFC, 1, 32'h0));
    v.push_back(cyc(0, 0, 0, 1, 0, 1, 32'h0, 1, 32'h4));
    foreach (v[i]) begin
      tick(v[i]);
      got = {s_push, s_rmask, v[i].push ? s_pkt : 96'h0, v[i].req ? s_addr : 32'h0};
      exp = {v[i].push, v[i].req ? 4'hF : 4'h0,
             v[i].push ? {v[i].ppc, v[i].ppc ^ K, v[i].ppc + 32'd4} : 96'h0,
             v[i].req ? v[i].addr : 32'h0};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL wrap[%0d]: got=%h required=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_idle_resp();
    vec_t v[$];
    logic [132:0] got, exp;
    do_reset();
    v.push_back(cyc(0, 0, 1, 1, 1, 0, 0, 0, 0));
    v.push_back(cyc(0, 0, 0, 1, 0, 0, 0, 1, B));
    v.push_back(cyc(0, 0, 0, 1, 0, 1, B, 1, B + 32'h4));
    foreach (v[i]) begin
      tick(v[i]);
      got = {s_push, s_rmask, v[i].push ? s_pkt : 96'h0, v[i].req ? s_addr : 32'h0};
      exp = {v[i].push, v[i].req ? 4'hF : 4'h0,
             v[i].push ? {v[i].ppc, v[i].ppc ^ K, v[i].ppc + 32'd4} : 96'h0,
             v[i].req ? v[i].addr : 32'h0};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL idle_resp[%0d]: got=%h required=%h", i, got, exp);
      end
    end
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; iq_full = 1'b0;
    imem_resp = 1'b0; imem_rdata = '0; pend_v = 1'b0; pend_cnt = '0; pend_addr = '0;
    #1;
    test_reset();
    test_stream();
    test_full_hold();
    test_redirect_inflight();
    test_redirect_with_resp();
    test_double_redirect();
    test_wrap();
    test_idle_resp();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
